// File: rtl/count_wrap_monitor.sv
// Watches an up/down counter's output and direction, counts wraps in each direction,
// flags illegal jumps and queues wrap/jump events in a small first-word-fall-through FIFO.
module count_wrap_monitor #(
  parameter int CNT_W      = 4,
  parameter int WRAP_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              sel,
  input  logic              clr,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [1:0]        evt_code,
  output logic [CNT_W-1:0]  evt_cnt,
  output logic [WRAP_W-1:0] up_wraps,
  output logic [WRAP_W-1:0] dn_wraps,
  output logic              err,
  output logic              ovf
);

  typedef enum logic {IDLE, TRACK} state_t;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [1:0]        CODE_UP  = 2'b00;
  localparam logic [1:0]        CODE_DN  = 2'b01;
  localparam logic [1:0]        CODE_ERR = 2'b10;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
  localparam logic [AW:0]       FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0]     PTR_ONE  = AW'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   prevCnt_q, prevCnt_d;
  logic               prevSel_q, prevSel_d;
  logic [WRAP_W-1:0]  upWraps_q, upWraps_d;
  logic [WRAP_W-1:0]  dnWraps_q, dnWraps_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;
  logic [AW-1:0]      wrPtr_q, wrPtr_d;
  logic [AW-1:0]      rdPtr_q, rdPtr_d;
  logic [AW:0]        count_q, count_d;
  logic [1:0]         codeMem_q [FIFO_DEPTH];
  logic [CNT_W-1:0]   cntMem_q  [FIFO_DEPTH];

  logic               push, pushOk, pop, full;
  logic [1:0]         pushCode;

  assign full      = (count_q == FULL_CNT);
  assign evt_valid = (count_q != '0);
  assign pop       = evt_valid && evt_ready;
  assign evt_code  = evt_valid ? codeMem_q[rdPtr_q] : 2'b00;
  assign evt_cnt   = evt_valid ? cntMem_q[rdPtr_q] : '0;
  assign up_wraps  = upWraps_q;
  assign dn_wraps  = dnWraps_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

  // Step classification against the previous sample, plus FIFO bookkeeping
  always_comb begin
    state_d   = state_q;
    prevCnt_d = prevCnt_q;
    prevSel_d = prevSel_q;
    upWraps_d = upWraps_q;
    dnWraps_d = dnWraps_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    pushCode  = CODE_UP;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d   = TRACK;
          prevCnt_d = cnt;
          prevSel_d = sel;
        end
      end
      TRACK: begin
        if (en) begin
          prevCnt_d = cnt;
          prevSel_d = sel;
          if (cnt != prevCnt_q) begin
            if (prevSel_q && (cnt == prevCnt_q + CNT_ONE)) begin
              if (prevCnt_q == CNT_MAX) begin
                push     = 1'b1;
                pushCode = CODE_UP;
                if (upWraps_q != WRAP_MAX) upWraps_d = upWraps_q + WRAP_ONE;
              end
            end else if (!prevSel_q && (cnt == prevCnt_q - CNT_ONE)) begin
              if (prevCnt_q == '0) begin
                push     = 1'b1;
                pushCode = CODE_DN;
                if (dnWraps_q != WRAP_MAX) dnWraps_d = dnWraps_q + WRAP_ONE;
              end
            end else begin
              push     = 1'b1;
              pushCode = CODE_ERR;
              err_d    = 1'b1;
            end
          end
        end
      end
    endcase

    // A full FIFO still accepts a push when the head leaves in the same cycle
    pushOk = push && (!full || pop);
    if (push && full && !pop) ovf_d = 1'b1;
    wrPtr_d = pushOk ? wrPtr_q + PTR_ONE : wrPtr_q;
    rdPtr_d = pop ? rdPtr_q + PTR_ONE : rdPtr_q;
    count_d = count_q;
    if (pushOk && !pop) count_d = count_q + 1'b1;
    else if (!pushOk && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q   <= IDLE;
      prevCnt_q <= '0;
      prevSel_q <= 1'b0;
      upWraps_q <= '0;
      dnWraps_q <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      prevCnt_q <= prevCnt_d;
      prevSel_q <= prevSel_d;
      upWraps_q <= upWraps_d;
      dnWraps_q <= dnWraps_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset; the outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (pushOk) begin
      codeMem_q[wrPtr_q] <= pushCode;
      cntMem_q[wrPtr_q]  <= cnt;
    end
  end

endmodule
